// File: rtl/ddr3_cmd_arbiter.sv
// DDR3 command arbiter: round-robin grant over four bank FSMs plus refresh,
// with the winning command encoded onto registered DDR3 command/address pins.
package ddr3_pkg;
  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACTIVATE,
    CMD_READ,
    CMD_WRITE,
    CMD_PRECHARGE,
    CMD_PRECHARGE_ALL,
    CMD_REFRESH
  } ddr3_cmd_t;

  typedef enum logic [1:0] {
    BANK_0,
    BANK_1,
    BANK_2,
    BANK_3
  } bank_t;
endpackage

module ddr3_cmd_arbiter
  import ddr3_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int A10_BIT    = 10,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_BANKS-1:0]  bank_cmd_valid,
  input  ddr3_cmd_t             bank_cmd_type [NUM_BANKS],
  input  logic [ADDR_WIDTH-1:0] bank_cmd_addr [NUM_BANKS],
  output bank_t                 next_prio_bank,
  output logic [NUM_BANKS-1:0]  bank_cmd_ready,
  input  logic                  ref_cmd_valid,
  input  ddr3_cmd_t             ref_cmd_type,
  output logic                  ref_cmd_ready,
  output logic                  ddr_cs_n,
  output logic                  ddr_ras_n,
  output logic                  ddr_cas_n,
  output logic                  ddr_we_n,
  output logic [1:0]            ddr_ba,
  output logic [ADDR_WIDTH-1:0] ddr_addr,
  output logic                  issued_valid,
  output bank_t                 issued_bank
);

  bank_t                 ptr;
  logic [1:0]            gnt;
  logic [1:0]            idx;
  logic                  hit;
  ddr3_cmd_t             sel_cmd;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]            sel_bank;
  logic [3:0]            nxt_pins;
  logic [1:0]            nxt_ba;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic                  nxt_vld;

  // Scan from the farthest offset down so the nearest valid bank wins.
  always_comb begin
    gnt = ptr;
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_BANKS - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (bank_cmd_valid[idx]) begin
        gnt = idx;
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    bank_cmd_ready = '0;
    if (hit && (gnt != ptr))
      bank_cmd_ready[gnt] = 1'b1;
  end

  assign ref_cmd_ready  = ref_cmd_valid & ~hit;
  assign next_prio_bank = ptr;

  always_comb begin
    sel_cmd  = CMD_NOP;
    sel_addr = '0;
    sel_bank = '0;
    if (hit) begin
      sel_cmd  = bank_cmd_type[gnt];
      sel_addr = bank_cmd_addr[gnt];
      sel_bank = gnt;
    end else if (ref_cmd_valid) begin
      sel_cmd = ref_cmd_type;
    end
  end

  always_comb begin
    nxt_pins = 4'b0111;
    nxt_ba   = '0;
    nxt_addr = '0;
    nxt_vld  = 1'b0;
    unique case (1'b1)
      (sel_cmd == CMD_ACTIVATE): begin
        nxt_pins = 4'b0011;
        nxt_ba   = sel_bank;
        nxt_addr = sel_addr;
        nxt_vld  = 1'b1;
      end
      (sel_cmd == CMD_READ),
      (sel_cmd == CMD_WRITE): begin
        nxt_pins = (sel_cmd == CMD_READ) ? 4'b0101 : 4'b0100;
        nxt_ba   = sel_bank;
        nxt_addr = sel_addr;
        nxt_addr[A10_BIT] = 1'b0;
        nxt_vld  = 1'b1;
      end
      (sel_cmd == CMD_PRECHARGE): begin
        nxt_pins = 4'b0010;
        nxt_ba   = sel_bank;
        nxt_vld  = 1'b1;
      end
      (sel_cmd == CMD_PRECHARGE_ALL): begin
        nxt_pins = 4'b0010;
        nxt_addr[A10_BIT] = 1'b1;
        nxt_vld  = 1'b1;
      end
      (sel_cmd == CMD_REFRESH): begin
        nxt_pins = 4'b0001;
        nxt_vld  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= BANK_0;
      ddr_cs_n     <= 1'b1;
      ddr_ras_n    <= 1'b1;
      ddr_cas_n    <= 1'b1;
      ddr_we_n     <= 1'b1;
      ddr_ba       <= '0;
      ddr_addr     <= '0;
      issued_valid <= 1'b0;
      issued_bank  <= BANK_0;
    end else begin
      if (hit)
        ptr <= bank_t'(gnt + 2'd1);
      {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} <= nxt_pins;
      ddr_ba       <= nxt_ba;
      ddr_addr     <= nxt_addr;
      issued_valid <= nxt_vld;
      issued_bank  <= bank_t'(nxt_ba);
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Bench for ddr3_cmd_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level round-robin / encoding model.
module tb_ddr3_cmd_arbiter;
  import ddr3_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  vld;
  ddr3_cmd_t   typ [4];
  logic [13:0] adr [4];
  bank_t       prio;
  logic [3:0]  rdy;
  logic        ref_v;
  ddr3_cmd_t   ref_t;
  logic        ref_r;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [13:0] addr;
  logic        iss_v;
  bank_t       iss_b;
  logic [3:0]  pins;

  int checks = 0;
  int errors = 0;
  int mptr;

  assign pins = {cs_n, ras_n, cas_n, we_n};

  always #5 clk = ~clk;

  ddr3_cmd_arbiter #(
    .NUM_BANKS (4),
    .A10_BIT   (10),
    .ADDR_WIDTH(14)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bank_cmd_valid(vld),
    .bank_cmd_type (typ),
    .bank_cmd_addr (adr),
    .next_prio_bank(prio),
    .bank_cmd_ready(rdy),
    .ref_cmd_valid (ref_v),
    .ref_cmd_type  (ref_t),
    .ref_cmd_ready (ref_r),
    .ddr_cs_n      (cs_n),
    .ddr_ras_n     (ras_n),
    .ddr_cas_n     (cas_n),
    .ddr_we_n      (we_n),
    .ddr_ba        (ba),
    .ddr_addr      (addr),
    .issued_valid  (iss_v),
    .issued_bank   (iss_b)
  );

  function automatic int model_pick(input logic [3:0] v, input int p);
    for (int off = 0; off < 4; off++)
      if (v[(p + off) % 4]) return (p + off) % 4;
    return -1;
  endfunction

  // {issued_valid, pins, ba, addr}
  function automatic logic [20:0] model_enc(input ddr3_cmd_t c, input int b,
                                            input logic [13:0] a);
    case (c)
      CMD_ACTIVATE:      return {1'b1, 4'b0011, 2'(b), a};
      CMD_READ:          return {1'b1, 4'b0101, 2'(b), a & 14'h3BFF};
      CMD_WRITE:         return {1'b1, 4'b0100, 2'(b), a & 14'h3BFF};
      CMD_PRECHARGE:     return {1'b1, 4'b0010, 2'(b), 14'h0};
      CMD_PRECHARGE_ALL: return {1'b1, 4'b0010, 2'b00, 14'h400};
      CMD_REFRESH:       return {1'b1, 4'b0001, 2'b00, 14'h0};
      default:           return {1'b0, 4'b0111, 2'b00, 14'h0};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    vld   = 4'b0;
    ref_v = 1'b0;
    ref_t = CMD_REFRESH;
    for (int i = 0; i < 4; i++) begin
      typ[i] = CMD_NOP;
      adr[i] = 14'h0;
    end
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({iss_v, pins, ba, addr} !== {1'b0, 4'b1111, 2'b00, 14'h0}) begin
      errors++;
      $display("FAIL reset_pins got %b %b %h %h exp 0 1111 0 0",
               iss_v, pins, ba, addr);
    end
    checks++;
    if (prio !== BANK_0) begin
      errors++;
      $display("FAIL reset_ptr got %0d exp 0", prio);
    end
    vld = 4'b0010; typ[1] = CMD_ACTIVATE; adr[1] = 14'h0123;
    tick();
    checks++;
    if ({iss_v, pins, ba, addr} !== {1'b1, 4'b0011, 2'd1, 14'h0123}) begin
      errors++;
      $display("FAIL t1_act got %b %b %h %h exp 1 0011 1 0123",
               iss_v, pins, ba, addr);
    end
    vld = 4'b0001; typ[0] = CMD_ACTIVATE;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({iss_v, cs_n, pins, prio} !== {1'b0, 1'b1, 4'b1111, BANK_0}) begin
      errors++;
      $display("FAIL t1_async got v%b cs%b pins%b ptr%0d exp v0 cs1 1111 ptr0",
               iss_v, cs_n, pins, prio);
    end
    tick();
    checks++;
    if ({iss_v, pins, prio} !== {1'b0, 4'b1111, BANK_0}) begin
      errors++;
      $display("FAIL t1_held got v%b pins%b ptr%0d exp v0 1111 ptr0",
               iss_v, pins, prio);
    end
    clear_in();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    vld = 4'b0100; typ[2] = CMD_ACTIVATE; adr[2] = 14'h01A5;
    #1;
    checks++;
    if ({rdy, ref_r} !== {4'b0100, 1'b0}) begin
      errors++;
      $display("FAIL t2_ready got %b %b exp 0100 0", rdy, ref_r);
    end
    tick();
    checks++;
    if ({pins, ba, addr, iss_v, iss_b, prio} !==
        {4'b0011, 2'd2, 14'h01A5, 1'b1, BANK_2, BANK_3}) begin
      errors++;
      $display("FAIL t2_pins got %b %0d %h v%b b%0d ptr%0d exp 0011 2 1a5 1 2 3",
               pins, ba, addr, iss_v, iss_b, prio);
    end
    clear_in();
  endtask

  task automatic test_fairness();
    logic [13:0] a [4];
    do_reset();
    vld = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      typ[i] = CMD_READ;
      a[i]   = 14'($urandom);
      adr[i] = a[i];
    end
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if ({rdy, prio} !== {4'b0000, 2'(c % 4)}) begin
        errors++;
        $display("FAIL t3_grant c%0d got rdy %b ptr %0d exp 0000 %0d",
                 c, rdy, prio, c % 4);
      end
      tick();
      checks++;
      if ({pins, ba, addr} !== {4'b0101, 2'(c % 4), a[c % 4] & 14'h3BFF}) begin
        errors++;
        $display("FAIL t3_pins c%0d got %b %0d %h exp 0101 %0d %h",
                 c, pins, ba, addr, c % 4, a[c % 4] & 14'h3BFF);
      end
    end
    clear_in();
  endtask

  task automatic test_refresh();
    vld = 4'b0010; typ[1] = CMD_ACTIVATE; adr[1] = 14'h0055;
    ref_v = 1'b1; ref_t = CMD_REFRESH;
    #1;
    checks++;
    if ({ref_r, rdy} !== {1'b0, 4'b0010}) begin
      errors++;
      $display("FAIL t4_block got ref %b rdy %b exp 0 0010", ref_r, rdy);
    end
    tick();
    vld = 4'b0000;
    #1;
    checks++;
    if ({ref_r, rdy} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL t4_grant got ref %b rdy %b exp 1 0000", ref_r, rdy);
    end
    tick();
    checks++;
    if ({pins, ba, addr, iss_v, prio} !== {4'b0001, 2'd0, 14'h0, 1'b1, BANK_2}) begin
      errors++;
      $display("FAIL t4_pins got %b %0d %h v%b ptr%0d exp 0001 0 0 1 2",
               pins, ba, addr, iss_v, prio);
    end
    clear_in();
  endtask

  task automatic test_encode();
    vld = 4'b1000; typ[3] = CMD_WRITE; adr[3] = 14'h07FF;
    #1;
    checks++;
    if (rdy !== 4'b1000) begin
      errors++;
      $display("FAIL t5_ready got %b exp 1000", rdy);
    end
    tick();
    checks++;
    if ({pins, ba, addr, prio} !== {4'b0100, 2'd3, 14'h03FF, BANK_0}) begin
      errors++;
      $display("FAIL t5_write got %b %0d %h ptr%0d exp 0100 3 3ff 0",
               pins, ba, addr, prio);
    end
    clear_in();
    ref_v = 1'b1; ref_t = CMD_PRECHARGE_ALL;
    tick();
    checks++;
    if ({pins, ba, addr, iss_v} !== {4'b0010, 2'd0, 14'h0400, 1'b1}) begin
      errors++;
      $display("FAIL t5_prea got %b %0d %h v%b exp 0010 0 400 1",
               pins, ba, addr, iss_v);
    end
    clear_in();
    vld = 4'b0001; typ[0] = CMD_PRECHARGE; adr[0] = 14'h15AB;
    tick();
    checks++;
    if ({pins, ba, addr, prio} !== {4'b0010, 2'd0, 14'h0, BANK_1}) begin
      errors++;
      $display("FAIL t5_pre got %b %0d %h ptr%0d exp 0010 0 0 1",
               pins, ba, addr, prio);
    end
    clear_in();
    tick();
    checks++;
    if ({pins, ba, addr, iss_v} !== {4'b0111, 2'd0, 14'h0, 1'b0}) begin
      errors++;
      $display("FAIL t5_nop got %b %0d %h v%b exp 0111 0 0 0",
               pins, ba, addr, iss_v);
    end
  endtask

  task automatic test_wrap();
    vld = 4'b0100; typ[2] = CMD_ACTIVATE;
    tick();
    vld = 4'b0011; typ[0] = CMD_ACTIVATE; typ[1] = CMD_ACTIVATE;
    adr[0] = 14'h0AAA; adr[1] = 14'h0BBB;
    #1;
    checks++;
    if ({rdy, prio} !== {4'b0001, BANK_3}) begin
      errors++;
      $display("FAIL t6_ready got %b ptr%0d exp 0001 3", rdy, prio);
    end
    tick();
    checks++;
    if ({ba, addr, prio} !== {2'd0, 14'h0AAA, BANK_1}) begin
      errors++;
      $display("FAIL t6_wrap got %0d %h ptr%0d exp 0 aaa 1", ba, addr, prio);
    end
    clear_in();
  endtask

  task automatic test_random();
    int          g;
    logic [3:0]  e_rdy;
    logic        e_ref;
    logic [20:0] e;
    do_reset();
    mptr = 0;
    for (int c = 0; c < 400; c++) begin
      vld   = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      ref_v = 1'($urandom);
      ref_t = $urandom_range(0, 1) ? CMD_REFRESH : CMD_PRECHARGE_ALL;
      for (int i = 0; i < 4; i++) begin
        adr[i] = 14'($urandom);
        case ($urandom_range(0, 4))
          0:       typ[i] = CMD_NOP;
          1:       typ[i] = CMD_ACTIVATE;
          2:       typ[i] = CMD_READ;
          3:       typ[i] = CMD_WRITE;
          default: typ[i] = CMD_PRECHARGE;
        endcase
      end
      g = model_pick(vld, mptr);
      e_rdy = 4'b0;
      e_ref = 1'b0;
      if (g >= 0) begin
        if (g != mptr) e_rdy[g] = 1'b1;
        e = model_enc(typ[g], g, adr[g]);
      end else if (ref_v) begin
        e_ref = 1'b1;
        e = model_enc(ref_t, 0, 14'h0);
      end else begin
        e = model_enc(CMD_NOP, 0, 14'h0);
      end
      #1;
      checks++;
      if ({rdy, ref_r, prio} !== {e_rdy, e_ref, 2'(mptr)}) begin
        errors++;
        $display("FAIL rnd_grant c%0d got %b %b %0d exp %b %b %0d",
                 c, rdy, ref_r, prio, e_rdy, e_ref, mptr);
      end
      tick();
      checks++;
      if ({iss_v, pins, ba, addr} !== e || iss_b !== bank_t'(e[15:14])) begin
        errors++;
        $display("FAIL rnd_pins c%0d got %b %b %0d %h b%0d exp %h",
                 c, iss_v, pins, ba, addr, iss_b, e);
      end
      if (g >= 0) mptr = (g + 1) % 4;
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_refresh();
    test_encode();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
